// File: rtl/param_shift_reg.sv
// param_shift_reg: WIDTH-bit universal register with single-cycle ops and a counted multi-step shift
module param_shift_reg #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [2:0] mode_q, mode_d;
  logic done_q, done_d;
  logic is_cnt;
  function automatic logic [WIDTH-1:0] op(input logic [2:0] m, input logic [WIDTH-1:0] v,
                                          input logic [WIDTH-1:0] dv, input logic sl, input logic sr);
    case (m)
      3'b001:  op = dv;
      3'b010:  op = {v[WIDTH-2:0], sl};
      3'b011:  op = {sr, v[WIDTH-1:1]};
      3'b100:  op = {v[WIDTH-2:0], v[WIDTH-1]};
      3'b101:  op = {v[0], v[WIDTH-1:1]};
      3'b110:  op = {v[WIDTH-1], v[WIDTH-1:1]};
      3'b111:  op = '0;
      default: op = v;
    endcase
  endfunction
  assign is_cnt = start && mode != 3'b000 && mode != 3'b001 && mode != 3'b111;
  always_comb begin
    q_d = q_q;
    state_d = state_q;
    cnt_d = cnt_q;
    mode_d = mode_q;
    done_d = 1'b0;
    if (state_q == BUSY) begin
      q_d = op(mode_q, q_q, d, sin_l, sin_r);
      cnt_d = cnt_q - AMT_W'(1);
      state_d = cnt_q == AMT_W'(1) ? IDLE : BUSY;
      done_d = cnt_q == AMT_W'(1);
    end else if (is_cnt) begin
      mode_d = mode;
      q_d = amount != '0 ? op(mode, q_q, d, sin_l, sin_r) : q_q;
      cnt_d = amount > AMT_W'(1) ? amount - AMT_W'(1) : '0;
      state_d = amount > AMT_W'(1) ? BUSY : IDLE;
      done_d = amount <= AMT_W'(1);
    end else if (en || start) begin
      q_d = op(mode, q_q, d, sin_l, sin_r);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= RESET_VAL;
      state_q <= IDLE;
      cnt_q <= '0;
      mode_q <= 3'b000;
      done_q <= 1'b0;
    end else begin
      q_q <= q_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      mode_q <= mode_d;
      done_q <= done_d;
    end
  end
  assign q = q_q;
  assign sout_l = q_q[WIDTH-1];
  assign sout_r = q_q[0];
  assign busy = state_q == BUSY;
  assign done = done_q;
endmodule

// File: tb/tb_param_shift_reg.sv
// tb_param_shift_reg: directed test of param_shift_reg against a step-count behavioural model
module tb_param_shift_reg;
  logic clk = 1'b0;
  logic rst, en, sin_l, sin_r, start;
  logic [2:0] mode;
  logic [7:0] d;
  logic [3:0] amount;
  logic [7:0] q;
  logic sout_l, sout_r, busy, done;
  int n_chk = 0;
  int n_fail = 0;
  logic chk_on = 1'b0;
  logic [7:0] exp_q;
  logic exp_busy, exp_done;
  logic [2:0] lmode;
  int rem;

  param_shift_reg #(.WIDTH(8), .AMT_W(4), .RESET_VAL(8'hA5)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .sin_l(sin_l), .sin_r(sin_r),
    .start(start), .amount(amount), .q(q), .sout_l(sout_l), .sout_r(sout_r),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] op(input logic [2:0] m, input logic [7:0] v, input logic [7:0] dv,
                                    input logic sl, input logic sr);
    case (m)
      3'd1:    op = dv;
      3'd2:    op = (v << 1) | {7'b0, sl};
      3'd3:    op = (v >> 1) | {sr, 7'b0};
      3'd4:    op = (v << 1) | (v >> 7);
      3'd5:    op = (v >> 1) | (v << 7);
      3'd6:    op = (v >> 1) | (v & 8'h80);
      3'd7:    op = 8'h00;
      default: op = v;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      exp_q = 8'hA5;
      rem = 0;
      exp_done = 1'b0;
    end else begin
      exp_done = 1'b0;
      if (rem > 0) begin
        exp_q = op(lmode, exp_q, d, sin_l, sin_r);
        rem--;
        exp_done = rem == 0;
      end else if (start && mode inside {[3'd2:3'd6]}) begin
        lmode = mode;
        rem = int'(amount);
        if (rem > 0) begin
          exp_q = op(lmode, exp_q, d, sin_l, sin_r);
          rem--;
        end
        exp_done = rem == 0;
      end else if (en || start) begin
        exp_q = op(mode, exp_q, d, sin_l, sin_r);
      end
    end
    exp_busy = rem > 0;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_q", q, exp_q);
      chk("model_busy", busy, exp_busy);
      chk("model_done", done, exp_done);
      chk("model_sout_l", sout_l, exp_q[7]);
      chk("model_sout_r", sout_r, exp_q[0]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 20) begin
      step();
      k++;
    end
    chk("busy_bound", busy, 0);
  endtask

  initial begin
    rst = 1; en = 0; mode = 0; d = 0; sin_l = 0; sin_r = 0; start = 0; amount = 0;
    step();
    rst = 0;
    chk_on = 1'b1;
    chk("reset_q", q, 8'hA5);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    en = 1; mode = 3'd1; d = 8'h96; step(); chk("load", q, 8'h96);
    mode = 3'd2; sin_l = 1; step(); chk("shl", q, 8'h2D);
    mode = 3'd3; sin_r = 0; step(); chk("shr", q, 8'h16);
    mode = 3'd5; step(); chk("rotr", q, 8'h0B);
    mode = 3'd1; d = 8'h80; step();
    mode = 3'd6; step(); chk("asr", q, 8'hC0);
    mode = 3'd7; step(); chk("clear", q, 8'h00);
    en = 0; mode = 3'd2; step(); chk("en_low_hold", q, 8'h00);
    en = 1; mode = 3'd1; d = 8'h81; step();
    en = 0; mode = 3'd4; amount = 3; start = 1; step();
    chk("rotl_1", q, 8'h03); chk("rotl_busy1", busy, 1);
    start = 0; mode = 0; step();
    chk("rotl_2", q, 8'h06); chk("rotl_busy2", busy, 1); chk("rotl_nodone", done, 0);
    step();
    chk("rotl_3", q, 8'h0C); chk("rotl_done", done, 1); chk("rotl_idle", busy, 0);
    step(); chk("rotl_done_clr", done, 0);
    mode = 3'd2; amount = 0; start = 1; step();
    chk("amt0_q", q, 8'h0C); chk("amt0_done", done, 1); chk("amt0_busy", busy, 0);
    start = 0; step(); chk("amt0_done_clr", done, 0);
    sin_l = 0; amount = 1; start = 1; step();
    chk("amt1_q", q, 8'h18); chk("amt1_done", done, 1); chk("amt1_busy", busy, 0);
    start = 0; step(); chk("amt1_done_clr", done, 0);
    mode = 3'd3; sin_r = 0; amount = 4; start = 1; step();
    chk("shr4_1", q, 8'h0C);
    en = 1; mode = 3'd1; d = 8'hFF; amount = 7; step(); step(); step();
    chk("shr4_q", q, 8'h01); chk("shr4_done", done, 1);
    en = 0; mode = 3'd5; amount = 2; start = 1; step();
    chk("b2b_1", q, 8'h80); chk("b2b_busy", busy, 1);
    start = 0; mode = 0; step();
    chk("b2b_2", q, 8'h40); chk("b2b_done", done, 1);
    step(); chk("b2b_done_clr", done, 0);
    mode = 3'd2; sin_l = 1; amount = 5; start = 1; step();
    chk("pre_rst", q, 8'h81);
    start = 0; rst = 1; step();
    chk("midrst_q", q, 8'hA5); chk("midrst_busy", busy, 0); chk("midrst_done", done, 0);
    rst = 0; step(); chk("midrst_nodone", done, 0); chk("midrst_hold", q, 8'hA5);
    mode = 3'd4; amount = 9; start = 1; step();
    start = 0; mode = 0; wait_idle();
    chk("rotl9", q, 8'h4B); chk("rotl9_done", done, 1);
    mode = 3'd2; sin_l = 0; amount = 12; start = 1; step();
    start = 0; mode = 0; wait_idle();
    chk("shl12", q, 8'h00);
    step(); step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
